// File: rtl/home_auth_pkg.sv
// rtl/home_auth_pkg.sv - shared types and constants for the door authentication scheduler
package home_auth_pkg;

    localparam int PW_W = 17;
    localparam logic [PW_W-1:0] MASTER_KEY = 17'd45675;
    localparam logic [PW_W-1:0] DEFAULT_PW = 17'd45675;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ST_NONE    = 2'b00,
        ST_GRANTED = 2'b01,
        ST_DENIED  = 2'b10,
        ST_LOCKED  = 2'b11
    } status_e;

endpackage

// File: rtl/door_auth_scheduler_rr_arbiter.sv
// rtl/door_auth_scheduler_rr_arbiter.sv - round-robin winner pick starting after the last winner
module rr_arbiter #(
    parameter int N  = 9,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] grant_idx_o,
    output logic          grant_valid_o
);

    int cand;

    // Scan from farthest to nearest so the closest requester after last_i wins.
    always_comb begin
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        cand          = 0;
        for (int k = N; k >= 1; k--) begin
            cand = (int'(last_i) + k) % N;
            if (req_i[cand]) begin
                grant_idx_o   = IW'(cand);
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/door_auth_scheduler.sv
// rtl/door_auth_scheduler.sv - shared password checker for all doors; DOOR_LOCKOUT_TIMER_EN adds auto-unlock timers
module door_auth_scheduler #(
    parameter int NUM_DOORS      = 9,
    parameter int PW_W           = 17,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            reset_signal,
    input  logic [NUM_DOORS-1:0]            req_valid,
    input  logic [NUM_DOORS-1:0]            req_change,
    input  logic [NUM_DOORS-1:0][PW_W-1:0]  in_password,
    input  logic [NUM_DOORS-1:0][PW_W-1:0]  new_password,
    output logic [NUM_DOORS-1:0]            ack,
    output logic [1:0]                      status,
    output logic [NUM_DOORS-1:0]            unlock_pulse,
    output logic [NUM_DOORS-1:0]            intruder_alarm,
    output logic [NUM_DOORS-1:0]            locked_out,
    output logic                            busy
);
    import home_auth_pkg::*;

    localparam int IW = (NUM_DOORS > 1) ? $clog2(NUM_DOORS) : 1;
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam logic [PW_W-1:0] MK  = PW_W'(MASTER_KEY);
    localparam logic [PW_W-1:0] DPW = PW_W'(DEFAULT_PW);

    state_e              state_q, state_d;
    logic [IW-1:0]       last_q;
    logic [IW-1:0]       win_q;
    logic [PW_W-1:0]     pw_q;
    logic [PW_W-1:0]     npw_q;
    logic                chg_q;
    status_e             status_q;
    logic                unlock_q;

    logic [PW_W-1:0]     table_q [NUM_DOORS];
    logic [PW_W-1:0]     table_d [NUM_DOORS];
    logic [FW-1:0]       fail_q  [NUM_DOORS];
    logic [FW-1:0]       fail_d  [NUM_DOORS];
    logic [NUM_DOORS-1:0] locked_q, locked_d;
    logic [NUM_DOORS-1:0] alarm_q,  alarm_d;

`ifdef DOOR_LOCKOUT_TIMER_EN
    localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    logic [TW-1:0]       timer_q [NUM_DOORS];
    logic [TW-1:0]       timer_d [NUM_DOORS];
`endif

    logic [IW-1:0]       grant_idx;
    logic                grant_valid;
    logic                is_master;
    logic                is_match;
    status_e             res_status;
    logic                res_unlock;

    rr_arbiter #(
        .N  (NUM_DOORS),
        .IW (IW)
    ) u_arb (
        .req_i         (req_valid),
        .last_i        (last_q),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    always_ff @(posedge clk or posedge reset_signal) begin
        if (reset_signal) state_q <= IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid) state_d = CHECK;
            CHECK:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != IDLE);
        ack          = '0;
        unlock_pulse = '0;
        status       = ST_NONE;
        if (state_q == RESP) begin
            ack[win_q]          = 1'b1;
            unlock_pulse[win_q] = unlock_q;
            status              = status_q;
        end
        locked_out     = locked_q;
        intruder_alarm = alarm_q;
    end

    assign is_master = (pw_q == MK);
    assign is_match  = is_master || (pw_q == table_q[win_q]);

    always_comb begin
        table_d    = table_q;
        fail_d     = fail_q;
        locked_d   = locked_q;
        alarm_d    = alarm_q;
        res_status = ST_NONE;
        res_unlock = 1'b0;
`ifdef DOOR_LOCKOUT_TIMER_EN
        timer_d = timer_q;
        for (int d = 0; d < NUM_DOORS; d++) begin
            if (locked_q[d]) begin
                if (timer_q[d] == '0) begin
                    locked_d[d] = 1'b0;
                    fail_d[d]   = '0;
                end else begin
                    timer_d[d] = timer_q[d] - 1'b1;
                end
            end
        end
`endif
        // The transaction in CHECK takes precedence over a same-cycle timer expiry.
        if (state_q == CHECK) begin
            if (locked_q[win_q] && !is_master) begin
                res_status = ST_LOCKED;
            end else if (is_match) begin
                res_status      = ST_GRANTED;
                fail_d[win_q]   = '0;
                locked_d[win_q] = 1'b0;
                if (is_master) alarm_d[win_q] = 1'b0;
                if (chg_q) table_d[win_q] = npw_q;
                else       res_unlock     = 1'b1;
            end else begin
                res_status = ST_DENIED;
                if (fail_q[win_q] != FW'(MAX_FAIL))
                    fail_d[win_q] = fail_q[win_q] + 1'b1;
                if (fail_q[win_q] >= FW'(MAX_FAIL - 1)) begin
                    locked_d[win_q] = 1'b1;
                    alarm_d[win_q]  = 1'b1;
`ifdef DOOR_LOCKOUT_TIMER_EN
                    timer_d[win_q]  = TW'(LOCKOUT_CYCLES - 1);
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset_signal) begin
        if (reset_signal) begin
            last_q   <= IW'(NUM_DOORS - 1);
            win_q    <= '0;
            pw_q     <= '0;
            npw_q    <= '0;
            chg_q    <= 1'b0;
            status_q <= ST_NONE;
            unlock_q <= 1'b0;
            locked_q <= '0;
            alarm_q  <= '0;
            for (int d = 0; d < NUM_DOORS; d++) begin
                table_q[d] <= DPW;
                fail_q[d]  <= '0;
`ifdef DOOR_LOCKOUT_TIMER_EN
                timer_q[d] <= '0;
`endif
            end
        end else begin
            if (state_q == IDLE && grant_valid) begin
                win_q  <= grant_idx;
                last_q <= grant_idx;
                pw_q   <= in_password[grant_idx];
                npw_q  <= new_password[grant_idx];
                chg_q  <= req_change[grant_idx];
            end
            if (state_q == CHECK) begin
                status_q <= res_status;
                unlock_q <= res_unlock;
            end
            table_q  <= table_d;
            fail_q   <= fail_d;
            locked_q <= locked_d;
            alarm_q  <= alarm_d;
`ifdef DOOR_LOCKOUT_TIMER_EN
            timer_q  <= timer_d;
`endif
        end
    end

endmodule

// File: tb/tb_door_auth_scheduler.sv
// tb/tb_door_auth_scheduler.sv - randomized self-checking bench against a behavioural door-access model
module tb_door_auth_scheduler;

    localparam int N  = 9;
    localparam int W  = 17;
    localparam int MF = 3;
    localparam logic [W-1:0] MK = 17'd45675;

    logic                 clk = 1'b0;
    logic                 reset_signal;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_change;
    logic [N-1:0][W-1:0]  in_password;
    logic [N-1:0][W-1:0]  new_password;
    logic [N-1:0]         ack;
    logic [1:0]           status;
    logic [N-1:0]         unlock_pulse;
    logic [N-1:0]         intruder_alarm;
    logic [N-1:0]         locked_out;
    logic                 busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] m_table [N];
    int           m_fail  [N];
    logic [N-1:0] m_locked;
    logic [N-1:0] m_alarm;
    int           m_last;

    always #5 clk = ~clk;

    door_auth_scheduler #(
        .NUM_DOORS      (N),
        .PW_W           (W),
        .MAX_FAIL       (MF),
        .LOCKOUT_CYCLES (1024)
    ) dut (
        .clk            (clk),
        .reset_signal   (reset_signal),
        .req_valid      (req_valid),
        .req_change     (req_change),
        .in_password    (in_password),
        .new_password   (new_password),
        .ack            (ack),
        .status         (status),
        .unlock_pulse   (unlock_pulse),
        .intruder_alarm (intruder_alarm),
        .locked_out     (locked_out),
        .busy           (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < N; d++) begin
            m_table[d] = MK;
            m_fail[d]  = 0;
        end
        m_locked = '0;
        m_alarm  = '0;
        m_last   = N - 1;
    endtask

    task automatic set_door(input int d, input logic [W-1:0] pw, input logic [W-1:0] np, input logic chg);
        in_password[d]  = pw;
        new_password[d] = np;
        req_change[d]   = chg;
    endtask

    task automatic run_batch(input logic [N-1:0] mask);
        logic [N-1:0] remaining;
        int           w;
        int           cyc;
        int           exp_st;
        logic         exp_unl;
        logic [W-1:0] pw;
        bit           first;
        remaining = mask;
        first     = 1'b1;
        @(negedge clk);
        req_valid = mask;
        while (remaining != '0) begin
            w = -1;
            for (int k = N; k >= 1; k--)
                if (remaining[(m_last + k) % N]) w = (m_last + k) % N;
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (ack == '0 && cyc < 20);
            if (ack == '0) begin
                check_val("ack_timeout", 32'(cyc), 32'(first ? 2 : 3));
                req_valid = '0;
                return;
            end
            check_val("ack_latency", 32'(cyc), 32'(first ? 2 : 3));
            check_val("ack_onehot", 32'(ack), 32'(1) << w);

            pw      = in_password[w];
            exp_unl = 1'b0;
            if (m_locked[w] && pw != MK) begin
                exp_st = 3;
            end else if (pw == MK || pw == m_table[w]) begin
                exp_st      = 1;
                m_fail[w]   = 0;
                m_locked[w] = 1'b0;
                if (pw == MK) m_alarm[w] = 1'b0;
                if (req_change[w]) m_table[w] = new_password[w];
                else               exp_unl    = 1'b1;
            end else begin
                exp_st = 2;
                m_fail[w] = (m_fail[w] + 1 > MF) ? MF : m_fail[w] + 1;
                if (m_fail[w] == MF) begin
                    m_locked[w] = 1'b1;
                    m_alarm[w]  = 1'b1;
                end
            end
            check_val("status", 32'(status), 32'(exp_st));
            check_val("unlock_pulse", 32'(unlock_pulse), exp_unl ? (32'(1) << w) : 32'(0));
            check_val("locked_out", 32'(locked_out), 32'(m_locked));
            check_val("intruder_alarm", 32'(intruder_alarm), 32'(m_alarm));
            m_last       = w;
            remaining[w] = 1'b0;
            req_valid[w] = 1'b0;
            first        = 1'b0;
        end
        @(negedge clk);
        check_val("idle_busy", 32'(busy), 32'(0));
        check_val("idle_ack", 32'(ack), 32'(0));
    endtask

    initial begin
        logic [N-1:0] mask;
        int           r;
        reset_signal = 1'b1;
        req_valid    = '0;
        req_change   = '0;
        in_password  = '0;
        new_password = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_ack", 32'(ack), 32'(0));
        check_val("rst_status", 32'(status), 32'(0));
        check_val("rst_unlock", 32'(unlock_pulse), 32'(0));
        check_val("rst_alarm", 32'(intruder_alarm), 32'(0));
        check_val("rst_locked", 32'(locked_out), 32'(0));
        check_val("rst_busy", 32'(busy), 32'(0));
        reset_signal = 1'b0;

        // Simultaneous requests from 0, 4, 8 served in round-robin order
        for (int d = 0; d < N; d++) set_door(d, MK, '0, 1'b0);
        run_batch(9'h111);
        run_batch(9'h008);

        // Door 2: new password, three wrong entries, locked reply, master release
        set_door(2, MK, 17'd999, 1'b1);
        run_batch(9'h004);
        set_door(2, 17'd1, '0, 1'b0);
        repeat (3) run_batch(9'h004);
        set_door(2, 17'd999, '0, 1'b0);
        run_batch(9'h004);
        set_door(2, MK, '0, 1'b0);
        run_batch(9'h004);

        // Door 5 password change only affects door 5
        set_door(5, MK, 17'd1234, 1'b1);
        run_batch(9'h020);
        set_door(5, 17'd1234, '0, 1'b0);
        run_batch(9'h020);
        set_door(6, 17'd1234, '0, 1'b0);
        run_batch(9'h040);

        for (int b = 0; b < 40; b++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int d = 0; d < N; d++) begin
                r = int'($urandom_range(0, 7));
                case (r)
                    0:       set_door(d, MK, 17'd1234, ($urandom_range(0, 3) == 0));
                    1, 2, 3: set_door(d, m_table[d], W'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
                    4, 5:    set_door(d, 17'd1, 17'd777, 1'b0);
                    default: set_door(d, W'($urandom_range(0, 15)), 17'd1234, ($urandom_range(0, 3) == 0));
                endcase
            end
            run_batch(mask);
        end

        // Reset during CHECK of a change request discards it
        set_door(7, MK, 17'd555, 1'b1);
        @(negedge clk);
        req_valid = 9'h080;
        @(posedge clk);
        #2;
        check_val("check_busy", 32'(busy), 32'(1));
        reset_signal = 1'b1;
        @(negedge clk);
        req_valid    = '0;
        reset_signal = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("rst_mid_ack", 32'(ack), 32'(0));
        end
        set_door(7, 17'd555, '0, 1'b0);
        run_batch(9'h080);
        set_door(7, MK, '0, 1'b0);
        run_batch(9'h080);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/door_auth_scheduler.md
DOOR_AUTH_SCHEDULER -- requirements
Module: door_auth_scheduler

Interface
REQ-001 Parameter NUM_DOORS, default 9: requesters 0-7 are the room doors and 8 is the garage.
REQ-002 Parameter PW_W, default 17: password width.
REQ-003 Parameter MAX_FAIL, default 3: consecutive wrong entries that trigger a door lockout.
REQ-004 Parameter LOCKOUT_CYCLES, default 1024: auto-lockout duration, used only under the Configuration macro.
REQ-005 Port clk, input, 1 bit: system clock, rising edge.
REQ-006 Port reset_signal, input, 1 bit: reset, asynchronous, active-high.
REQ-007 Port req_valid, input, NUM_DOORS bits: per-door entry request, held high until that door's ack.
REQ-008 Port req_change, input, NUM_DOORS bits: per-door flag; 1 requests a password change, 0 requests an unlock.
REQ-009 Port in_password, input, NUM_DOORS x PW_W: password entered at each keypad.
REQ-010 Port new_password, input, NUM_DOORS x PW_W: replacement password, used when req_change is 1.
REQ-011 Port ack, output, NUM_DOORS bits: one-cycle response strobe, one-hot or zero.
REQ-012 Port status, output, 2 bits: result valid with ack; 00 none, 01 granted, 10 denied, 11 locked.
REQ-013 Port unlock_pulse, output, NUM_DOORS bits: one-cycle unlock command to the door lock.
REQ-014 Port intruder_alarm, output, NUM_DOORS bits: sticky alarm per door.
REQ-015 Port locked_out, output, NUM_DOORS bits: current lockout state per door.
REQ-016 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-017 The block shall share a single password comparator among all doors through the FSM IDLE -> CHECK -> RESP -> IDLE.
REQ-018 In IDLE with any req_valid set, the block shall latch the winner index, its in_password, new_password and req_change, and move to CHECK.
REQ-019 Winner selection shall be round-robin, searching from (last winner + 1) mod NUM_DOORS; last winner resets to NUM_DOORS-1, so door 0 has first priority.
REQ-020 In CHECK, "match" shall be true when the latched password equals the door's table entry or the master key 17'd45675.
REQ-021 In CHECK, a locked door with no master-key match shall give status 11 with no change to its counter or table entry.
REQ-022 In CHECK, a locked door presenting the master key shall be cleared of lockout and fail count, then handled as a normal match.
REQ-023 On a match with req_change=0: status 01, fail count cleared, and unlock_pulse for the winner set in RESP.
REQ-024 On a match with req_change=1: status 01, table entry replaced by new_password in the same cycle, fail count cleared, and no unlock_pulse.
REQ-025 On a mismatch: status 10 and the fail count incremented, saturating at MAX_FAIL.
REQ-026 When the fail count reaches MAX_FAIL, the door shall set locked_out and intruder_alarm in the same cycle.
REQ-027 In RESP, ack[winner], status and the optional unlock_pulse shall all be high for exactly one cycle, then the FSM returns to IDLE; ack rises 2 cycles after the latch cycle.
REQ-028 A door dropping req_valid after the latch shall still be acked.
REQ-029 Back-to-back requests shall be served with no bubble beyond the 3-cycle service period.
REQ-030 intruder_alarm shall clear only on reset or on a master-key match from that door.
REQ-031 The password table shall be NUM_DOORS entries of PW_W bits, each reset to 17'd45675.

Reset
REQ-032 reset_signal shall asynchronously force: FSM to IDLE; ack, status, unlock_pulse, intruder_alarm, locked_out and busy to 0; all fail counts and lockout timers to 0; last winner to NUM_DOORS-1; the table to the default password.
REQ-033 Reset in CHECK or RESP shall discard the transaction: no ack, no table write.

Configuration
REQ-034 With macro DOOR_LOCKOUT_TIMER_EN defined, each locked door shall run a down-counter loaded with LOCKOUT_CYCLES-1, and shall auto-clear locked_out and its fail count on the cycle the counter reaches 0.
REQ-035 DOOR_LOCKOUT_TIMER_EN shall not clear intruder_alarm.
REQ-036 Without DOOR_LOCKOUT_TIMER_EN, lockout shall clear only on reset or master key, and no timer logic shall be present.

Structure
REQ-037 Package home_auth_pkg shall hold: the FSM state enum (IDLE, CHECK, RESP), the status encoding, MASTER_KEY and DEFAULT_PW (17'd45675), and PW_W.
REQ-038 Round-robin selection shall live in a sub-module rr_arbiter (request vector and last winner in; winner index and valid out).

Verification
REQ-039 Scenario: reset; door 3 requests 17'd45675 with change=0 -> ack[3] and unlock_pulse[3] 2 cycles after the latch cycle, status 01.
REQ-040 Scenario: doors 0, 4 and 8 request in the same cycle -> served in order 0, 4, 8, with acks 3 cycles apart.
REQ-041 Scenario: door 2 enters 17'd1 three times -> status 10 each time; after the third, locked_out[2]=1 and intruder_alarm[2]=1; a fourth correct non-master entry -> status 11.
REQ-042 Scenario: door 5 changes its password to 17'd1234, then enters 17'd1234 -> status 01 and unlock; door 6 entering 17'd1234 -> status 10.
REQ-043 Scenario: locked door 2 enters the master key -> status 01, locked_out[2]=0, intruder_alarm[2]=0; with DOOR_LOCKOUT_TIMER_EN, another lockout auto-clears after LOCKOUT_CYCLES.
REQ-044 Scenario: assert reset_signal in the CHECK cycle of a change request -> no ack, and the table entry stays 17'd45675.
